// File: rtl/prng_pkg.sv
// rtl/prng_pkg.sv - shared types and LFSR helpers for the shared PRNG arbiter
package prng_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      PAUSE  = 2'd1,
      RESEED = 2'd2
   } state_t;

   localparam int MAX_W = 32;

   localparam logic [7:0] TAPS_W8 = 8'hB8;

   // Maximal-length tap masks for the common widths; others fall back to a width-8 mask.
   function automatic logic [MAX_W-1:0] default_taps(input int width);
      case (width)
         3:       return MAX_W'(32'h6);
         4:       return MAX_W'(32'hC);
         5:       return MAX_W'(32'h14);
         6:       return MAX_W'(32'h30);
         7:       return MAX_W'(32'h60);
         8:       return MAX_W'(TAPS_W8);
         16:      return MAX_W'(32'hB400);
         default: return MAX_W'(TAPS_W8);
      endcase
   endfunction

   // Caller passes a zero-extended value and truncates the result back to its width.
   function automatic logic [MAX_W-1:0] lfsr_step(input logic [MAX_W-1:0] value,
                                                   input logic [MAX_W-1:0] taps);
      return {value[MAX_W-2:0], ^(value & taps)};
   endfunction

endpackage

// File: rtl/prng_lfsr_core.sv
// rtl/prng_lfsr_core.sv - N-bit Fibonacci LFSR register with step/load and zero-seed guard
module prng_lfsr_core
   import prng_pkg::*;
#(
   parameter int           N    = 8,
   parameter logic [N-1:0] TAPS = N'(default_taps(N)),
   parameter logic [N-1:0] SEED = N'(1)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         step,
   input  logic         load,
   input  logic [N-1:0] load_val,
   output logic [N-1:0] value
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         value <= SEED;
      end else if (load) begin
         // An all-zero seed would lock the LFSR up forever.
         value <= (load_val == '0) ? N'(1) : load_val;
      end else if (step) begin
         value <= N'(lfsr_step(MAX_W'(value), MAX_W'(TAPS)));
      end
   end

endmodule

// File: rtl/prng_share_arb.sv
// rtl/prng_share_arb.sv - round-robin sharing of one LFSR; PRNG_WRAP_FLAG_EN adds the wrap output
module prng_share_arb
   import prng_pkg::*;
#(
   parameter int           N       = 8,
   parameter int           NUM_REQ = 4,
   parameter logic [N-1:0] TAPS    = N'(default_taps(N)),
   parameter logic [N-1:0] SEED    = N'(1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               seed_load,
   input  logic [N-1:0]       seed_in,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic               rnd_valid,
   output logic [N-1:0]       rnd_data,
`ifdef PRNG_WRAP_FLAG_EN
   output logic               wrap,
`endif
   output logic               busy
);

   localparam int PTR_W = $clog2(NUM_REQ);

   state_t             state_q, state_d;
   logic [PTR_W-1:0]   rr_ptr;
   logic [PTR_W-1:0]   cand;
   logic [PTR_W-1:0]   win_idx;
   logic [PTR_W-1:0]   ptr_next;
   logic               win_found;
   logic               grant;
   logic [N-1:0]       lfsr_val;

   prng_lfsr_core #(
      .N    (N),
      .TAPS (TAPS),
      .SEED (SEED)
   ) u_core (
      .clk      (clk),
      .rst      (rst),
      .step     (grant),
      .load     (seed_load),
      .load_val (seed_in),
      .value    (lfsr_val)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (!en) state_d = PAUSE;
         PAUSE:   if (en)  state_d = RUN;
         RESEED:  state_d = RUN;
         default: state_d = RUN;
      endcase
      if (seed_load) state_d = RESEED;
   end

   // First requester at or after rr_ptr, wrapping around.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = PTR_W'((int'(rr_ptr) + i) % NUM_REQ);
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   assign grant    = (state_q == RUN) && en && !seed_load && win_found;
   assign ptr_next = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + PTR_W'(1);
   assign busy     = (state_q == RESEED);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= RUN;
         rr_ptr    <= '0;
         gnt       <= '0;
         rnd_valid <= 1'b0;
         rnd_data  <= '0;
      end else begin
         state_q   <= state_d;
         gnt       <= '0;
         rnd_valid <= grant;
         if (grant) begin
            gnt      <= NUM_REQ'(1) << win_idx;
            rnd_data <= lfsr_val;
            rr_ptr   <= ptr_next;
         end
      end
   end

`ifdef PRNG_WRAP_FLAG_EN
   logic [N-1:0] start_val;
   logic [N-1:0] lfsr_next;

   assign lfsr_next = N'(lfsr_step(MAX_W'(lfsr_val), MAX_W'(TAPS)));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         start_val <= SEED;
         wrap      <= 1'b0;
      end else begin
         if (seed_load) start_val <= (seed_in == '0) ? N'(1) : seed_in;
         wrap <= grant && (lfsr_next == start_val);
      end
   end
`endif

endmodule

// File: tb/tb_prng_share_arb.sv
// tb/tb_prng_share_arb.sv - scoreboard bench for prng_share_arb against a cycle-level reference model
module tb_prng_share_arb;

   localparam int         N    = 8;
   localparam int         NR   = 4;
   localparam logic [7:0] TAPS = 8'hB8;
   localparam logic [7:0] SEED = 8'h01;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          en = 1'b0;
   logic          seed_load = 1'b0;
   logic [N-1:0]  seed_in = '0;
   logic [NR-1:0] req = '0;
   logic [NR-1:0] gnt;
   logic          rnd_valid;
   logic [N-1:0]  rnd_data;
   logic          busy;
`ifdef PRNG_WRAP_FLAG_EN
   logic          wrap;
`endif

   prng_share_arb #(.N(N), .NUM_REQ(NR), .TAPS(TAPS), .SEED(SEED)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .seed_load (seed_load),
      .seed_in   (seed_in),
      .req       (req),
      .gnt       (gnt),
      .rnd_valid (rnd_valid),
      .rnd_data  (rnd_data),
`ifdef PRNG_WRAP_FLAG_EN
      .wrap      (wrap),
`endif
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int idx;
      int data;
      int wrp;
   } grant_t;

   grant_t exp_q[$];
   grant_t obs_q[$];
   int     busy_q[$];
   int     tests = 0;
   int     fails = 0;

   // Reference model: mode 0 = running, 1 = paused, 2 = reseeding.
   int m_lfsr, m_ptr, m_mode, m_start;

   function automatic int m_next(input int v);
      int fb;
      fb = $countones(v & int'(TAPS)) % 2;
      return ((v * 2) + fb) % 256;
   endfunction

   task automatic check(input string name, input int act, input int expv);
      tests++;
      if (act != expv) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   task automatic model_reset();
      m_lfsr  = int'(SEED);
      m_ptr   = 0;
      m_mode  = 0;
      m_start = int'(SEED);
      exp_q.delete();
      busy_q.delete();
   endtask

   task automatic model_cycle(input bit e, input bit sl, input int si, input logic [NR-1:0] rq,
                              output int won);
      int nxt;
      won = -1;
      if (sl) begin
         m_lfsr  = (si == 0) ? 1 : si;
         m_start = m_lfsr;
         m_mode  = 2;
         busy_q.push_back(1);
         return;
      end
      busy_q.push_back(0);
      if (m_mode == 2) begin
         m_mode = 0;
         return;
      end
      if (m_mode == 1) begin
         if (e) m_mode = 0;
         return;
      end
      if (!e) begin
         m_mode = 1;
         return;
      end
      for (int i = 0; i < NR; i++) begin
         if (rq[(m_ptr + i) % NR]) begin
            won = (m_ptr + i) % NR;
            break;
         end
      end
      if (won >= 0) begin
         nxt = m_next(m_lfsr);
         exp_q.push_back('{won, m_lfsr, (nxt == m_start) ? 1 : 0});
         m_lfsr = nxt;
         m_ptr  = (won + 1) % NR;
      end
   endtask

   task automatic drive(input bit e, input bit sl, input logic [N-1:0] si, input logic [NR-1:0] rq,
                        output int won);
      en        = e;
      seed_load = sl;
      seed_in   = si;
      req       = rq;
      model_cycle(e, sl, int'(si), rq, won);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      model_reset();
      obs_q.delete();
      en = 1'b0; seed_load = 1'b0; seed_in = '0; req = '0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      grant_t e;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            if (busy_q.size() > 0) check("busy", int'(busy), busy_q.pop_front());
            if (rnd_valid) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_grant", int'(gnt), 0);
               end else begin
                  e = exp_q.pop_front();
                  check("gnt", int'(gnt), 1 << e.idx);
                  check("rnd_data", int'(rnd_data), e.data);
`ifdef PRNG_WRAP_FLAG_EN
                  check("wrap", int'(wrap), e.wrp);
                  obs_q.push_back('{e.idx, int'(rnd_data), int'(wrap)});
`else
                  obs_q.push_back('{e.idx, int'(rnd_data), 0});
`endif
               end
            end else begin
               check("gnt_idle", int'(gnt), 0);
               check("missing_grant", exp_q.size(), 0);
            end
         end
      end
   end

   initial begin
      int won;
      int t1[5];
      int held;
      logic [NR-1:0] pend;
      t1 = '{1, 2, 4, 8, 'h11};

      // Reset values
      rst = 1'b0;
      model_reset();
      #2;
      check("reset_gnt", int'(gnt), 0);
      check("reset_valid", int'(rnd_valid), 0);
      check("reset_data", int'(rnd_data), 0);
      check("reset_busy", int'(busy), 0);
      do_reset();

      // Single requester held
      for (int i = 0; i < 5; i++) drive(1, 0, '0, 4'b0001, won);
      check("t1_count", obs_q.size(), 5);
      for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
         check("t1_idx", obs_q[i].idx, 0);
         check("t1_data", obs_q[i].data, t1[i]);
      end

      // All requesters held: rotation
      do_reset();
      for (int i = 0; i < 5; i++) drive(1, 0, '0, 4'b1111, won);
      check("t2_count", obs_q.size(), 5);
      for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
         check("t2_idx", obs_q[i].idx, i % 4);
         check("t2_data", obs_q[i].data, t1[i]);
      end

      // Zero reseed with a pending request
      obs_q.delete();
      drive(1, 1, 8'h00, 4'b0010, won);
      check("t3_busy", int'(busy), 1);
      drive(1, 0, 8'h00, 4'b0010, won);
      drive(1, 0, 8'h00, 4'b0010, won);
      check("t3_count", obs_q.size(), 1);
      if (obs_q.size() > 0) begin
         check("t3_idx", obs_q[0].idx, 1);
         check("t3_data", obs_q[0].data, 1);
      end

      // Pause with a pending request
      obs_q.delete();
      held = m_lfsr;
      for (int i = 0; i < 3; i++) drive(0, 0, '0, 4'b0100, won);
      check("t4_paused", obs_q.size(), 0);
      for (int i = 0; i < 2; i++) drive(1, 0, '0, 4'b0100, won);
      check("t4_count", obs_q.size(), 1);
      if (obs_q.size() > 0) begin
         check("t4_idx", obs_q[0].idx, 2);
         check("t4_data", obs_q[0].data, held);
      end

      // Reset while gnt[3] is up
      do_reset();
      for (int i = 0; i < 4; i++) drive(1, 0, '0, 4'b1111, won);
      check("t5_gnt3", int'(gnt), 8);
      rst = 1'b0;
      #1;
      check("t5_gnt", int'(gnt), 0);
      check("t5_valid", int'(rnd_valid), 0);
      check("t5_data", int'(rnd_data), 0);
      model_reset();
      obs_q.delete();
      @(negedge clk);
      rst = 1'b1;
      drive(1, 0, '0, 4'b0001, won);
      check("t5_count", obs_q.size(), 1);
      if (obs_q.size() > 0) check("t5_first", obs_q[0].data, 1);

`ifdef PRNG_WRAP_FLAG_EN
      do_reset();
      for (int i = 0; i < 256; i++) drive(1, 0, '0, 4'b0001, won);
      check("wrap_count", obs_q.size(), 256);
      if (obs_q.size() == 256) begin
         held = 0;
         foreach (obs_q[i]) held += obs_q[i].wrp;
         check("wrap_total", held, 1);
         check("wrap_at_255", obs_q[254].wrp, 1);
         check("wrap_256_data", obs_q[255].data, 1);
      end
`endif

      // Randomized traffic
      do_reset();
      pend = '0;
      for (int i = 0; i < 400; i++) begin
         pend = pend | NR'($urandom_range(0, 15) & $urandom_range(0, 15));
         drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 19) == 0),
               (($urandom_range(0, 3) == 0) ? 8'h00 : N'($urandom)), pend, won);
         if (won >= 0) pend[won] = 1'b0;
      end
      drive(1, 0, '0, '0, won);
      check("leftover_expected", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/prng_share_arb.md
Name: prng_share_arb

Overview:
- Owns one N-bit Fibonacci LFSR and shares it among NUM_REQ requesters using round-robin arbitration.
- Each grant returns one fresh random word and advances the LFSR exactly one step.
- Also sequences the generator: reseed, pause and resume.
- Sits between the PRNG datapath and consumer blocks (test-pattern, dither, backoff logic).

Parameters:
- N, 8, LFSR and output word width (min 3).
- NUM_REQ, 4, number of requesters (2..8).
- TAPS, 8'hB8, feedback tap mask, N bits wide; bit i set means lfsr[i] feeds back.
- SEED, 8'h01, reset value of the LFSR; must be nonzero.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  1 = serve requests; 0 = pause, LFSR frozen.
- seed_load  in  1  one-cycle pulse: load seed_in.
- seed_in  in  N  new seed value.
- req  in  NUM_REQ  per-requester request level, held until granted.
- gnt  out  NUM_REQ  one-hot grant pulse, registered.
- rnd_valid  out  1  high in the same cycle as any gnt bit.
- rnd_data  out  N  random word delivered with gnt.
- busy  out  1  1 in RESEED state.

Behaviour:
- Reset (rst=0, async) forces these values:
  - lfsr=SEED, gnt=0, rnd_valid=0, rnd_data=0, rr_ptr=0, busy=0, state=RUN.
- LFSR step: fb = XOR-reduce(lfsr & TAPS); lfsr_next = {lfsr[N-2:0], fb}.
- The LFSR steps only on a grant cycle. It never free-runs.
- FSM states are RUN, PAUSE and RESEED.
- Transition priority is seed_load > en.
  - Any state with seed_load=1 goes to RESEED. lfsr takes seed_in, or 1 if seed_in==0 (lockup guard). No grant is issued that cycle.
  - RESEED always goes to RUN next cycle. busy=1 and no grants for that one cycle.
  - RUN with en=0 goes to PAUSE. PAUSE with en=1 goes to RUN.
- Arbitration happens in RUN only, one grant per cycle max.
  - Search req starting at index rr_ptr, wrapping NUM_REQ-1 to 0.
  - The first set bit k wins.
  - Registered outputs next cycle: gnt[k]=1, rnd_valid=1, rnd_data = current lfsr (pre-step value).
  - Same edge: lfsr steps and rr_ptr = (k+1) mod NUM_REQ.
- Latency: req high and sampled at edge t gives gnt at edge t+1. Requester drops req the cycle after seeing gnt.
  - A req still high when gnt is seen may be re-granted, but only after rr_ptr rotates past it.
- No req, or not in RUN: gnt=0, rnd_valid=0, and rnd_data holds its last value.
- seed_load in the same cycle as a winning req: the seed wins. The req stays pending and is served after RESEED.
- en falling with a req pending: no grant. The pointer and LFSR are unchanged.
- Reset mid-grant: outputs clear immediately (async). No partial state survives.

Optional Feature:
- Macro: PRNG_WRAP_FLAG_EN.
- Defined:
  - Adds output port wrap (1 bit) and internal register start_val, loaded with the SEED/reseed value.
  - wrap pulses for one cycle, aligned with rnd_valid, when a stepped lfsr_next equals start_val (full period completed).
  - For N=8 with default taps, wrap fires on grant 255.
- Undefined: no wrap port and no start_val register. Behaviour is otherwise identical.

Decomposition:
- Package prng_pkg holds:
  - state enum {RUN, PAUSE, RESEED} as a 2-bit typedef.
  - Default TAPS constant per width (8 -> 8'hB8).
  - Function lfsr_step(value, taps).
- Sub-module prng_lfsr_core: the N-bit register with step and load inputs, seed-zero guard inside.
- The arbiter and FSM stay in prng_share_arb.

Test Plan:
- Reset with defaults, then req=4'b0001 held for 5 cycles -> gnt[0] pulses with rnd_data 01, 02, 04, 08, 11. One grant per cycle.
- req=4'b1111 held from reset -> gnt order 0,1,2,3,0. rnd_data 01,02,04,08,11. No gaps.
- seed_load=1 with seed_in=8'h00 while req=4'b0010 -> busy=1 for one cycle, no gnt. Next gnt[1] carries rnd_data=01.
- en=0 for 3 cycles with req=4'b0100 -> no gnt and lfsr frozen. After en=1, gnt[2] arrives next cycle with the held value.
- Assert rst=0 in the cycle gnt[3]=1 -> gnt, rnd_valid and rnd_data are 0 immediately. After release, the first grant returns 01.
- With PRNG_WRAP_FLAG_EN, hold req=4'b0001 for 255 grants -> wrap=1 only on grant 255. Grant 256 has rnd_data=01.
